// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/memory-stage arbiter onto a single-port memory.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of D-grants taken while a fetch request waits.
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and memory-stage requests onto one single-port memory,
// one transaction at a time, with D priority bounded by a starvation limit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [PC_W-1:0]   if_addr_i,
    input  logic              if_kill_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [PC_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [PC_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    arb_state_t        r_state;
    arb_gnt_t          r_gnt;
    logic              r_kill;
    logic              r_mem_req, r_mem_we;
    logic [PC_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
    logic              r_if_valid, r_dm_valid;

    logic w_sat, w_gnt_i, w_gnt_d, w_idle, w_starve_inc, w_starve_clr;

    assign w_idle  = (r_state == IDLE);
    assign w_gnt_i = w_idle & if_req_i & (~dm_req_i | w_sat);
    assign w_gnt_d = w_idle & dm_req_i & ~w_gnt_i;

    assign w_starve_inc = w_gnt_d & if_req_i;
    assign w_starve_clr = w_gnt_i | (w_idle & ~if_req_i);

    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_starve_inc),
        .i_clr (w_starve_clr),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_gnt       <= GNT_I;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_i) begin
                        r_state     <= BUSY_I;
                        r_gnt       <= GNT_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr_i;
                        r_mem_wdata <= '0;
                    end else if (w_gnt_d) begin
                        r_state     <= BUSY_D;
                        r_gnt       <= GNT_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we_i;
                        r_mem_addr  <= dm_addr_i;
                        r_mem_wdata <= dm_wdata_i;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (r_gnt == GNT_D) begin
                            r_dm_rdata <= mem_rdata_i;
                            r_dm_valid <= 1'b1;
                        end else if (!(r_kill || if_kill_i)) begin
                            // a killed fetch still drains the memory but is never delivered
                            r_if_rdata <= mem_rdata_i;
                            r_if_valid <= 1'b1;
                        end
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (r_state == RESP) begin
                r_kill <= 1'b0;
            end else if (r_state == BUSY_I && if_kill_i) begin
                r_kill <= 1'b1;
            end
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign if_rdata_o  = r_if_rdata;
    assign if_valid_o  = r_if_valid;
    assign dm_rdata_o  = r_dm_rdata;
    assign dm_valid_o  = r_dm_valid;

    assign if_stall_o = if_req_i & ~if_valid_o;
    assign dm_stall_o = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, kill, store, reset.
module tb_mem_arbiter;
    localparam int PC_W   = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req_i, if_kill_i, dm_req_i, dm_we_i, mem_ack_i;
    logic [PC_W-1:0]   if_addr_i, dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i, mem_rdata_i;
    logic [DATA_W-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
    logic              if_valid_o, if_stall_o, dm_valid_o, dm_stall_o, mem_req_o, mem_we_o;
    logic [PC_W-1:0]   mem_addr_o;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.PC_W(PC_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; if_req_i = 0; if_kill_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_if_valid", if_valid_o, 0);
        chk("rst_dm_valid", dm_valid_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // single fetch, ack one cycle after mem_req_o rises
        if_req_i = 1; if_addr_i = 32'h10; #1;
        chk("f_c0_stall", if_stall_o, 1);
        chk("f_c0_req", mem_req_o, 0);
        tick();
        chk("f_c1_req", mem_req_o, 1);
        chk("f_c1_addr", mem_addr_o, 32'h10);
        chk("f_c1_we", mem_we_o, 0);
        chk("f_c1_stall", if_stall_o, 1);
        tick();
        chk("f_c2_req", mem_req_o, 1);
        chk("f_c2_valid", if_valid_o, 0);
        chk("f_c2_stall", if_stall_o, 1);
        mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
        tick();
        mem_ack_i = 0;
        chk("f_c3_valid", if_valid_o, 1);
        chk("f_c3_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("f_c3_stall", if_stall_o, 0);
        chk("f_c3_req", mem_req_o, 0);
        if_req_i = 0;
        tick();
        chk("f_c4_valid", if_valid_o, 0);
        chk("f_c4_rdata_hold", if_rdata_o, 32'hDEADBEEF);

        // simultaneous I and D: D wins, I follows after D RESP
        if_req_i = 1; if_addr_i = 32'h20; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h40;
        tick();
        chk("s_d_addr", mem_addr_o, 32'h40);
        chk("s_d_stall", dm_stall_o, 1);
        mem_ack_i = 1; mem_rdata_i = 32'hAAAA0001;
        tick();
        mem_ack_i = 0;
        chk("s_d_valid", dm_valid_o, 1);
        chk("s_d_rdata", dm_rdata_o, 32'hAAAA0001);
        chk("s_i_novalid", if_valid_o, 0);
        dm_req_i = 0;
        tick();
        chk("s_idle_req", mem_req_o, 0);
        tick();
        chk("s_i_req", mem_req_o, 1);
        chk("s_i_addr", mem_addr_o, 32'h20);
        mem_ack_i = 1; mem_rdata_i = 32'h11112222;
        tick();
        mem_ack_i = 0;
        chk("s_i_valid", if_valid_o, 1);
        chk("s_i_rdata", if_rdata_o, 32'h11112222);
        chk("s_d_rdata_hold", dm_rdata_o, 32'hAAAA0001);
        if_req_i = 0;
        tick();

        // starvation: four D-grants, then I wins despite dm_req_i
        if_req_i = 1; if_addr_i = 32'h30;
        dm_req_i = 1; dm_we_i = 1; dm_wdata_i = 32'h99; dm_addr_i = 32'h100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_d_addr", mem_addr_o, 32'h100 + 32'(i));
            chk("st_d_we", mem_we_o, 1);
            mem_ack_i = 1;
            tick();
            mem_ack_i = 0;
            chk("st_d_valid", dm_valid_o, 1);
            dm_addr_i = 32'h100 + 32'(i + 1);
            tick();
        end
        tick();
        chk("st_i_addr", mem_addr_o, 32'h30);
        chk("st_i_we", mem_we_o, 0);
        mem_ack_i = 1; mem_rdata_i = 32'h3333;
        tick();
        mem_ack_i = 0;
        chk("st_i_valid", if_valid_o, 1);
        chk("st_d_novalid", dm_valid_o, 0);
        if_req_i = 0;
        tick();
        tick();
        chk("st_d_after", mem_addr_o, 32'h104);
        mem_ack_i = 1;
        tick();
        mem_ack_i = 0;
        chk("st_d_after_valid", dm_valid_o, 1);
        dm_req_i = 0; dm_we_i = 0;
        tick();

        // kill during BUSY_I: transaction completes, no if_valid_o
        if_req_i = 1; if_addr_i = 32'h50;
        tick();
        chk("k_req", mem_req_o, 1);
        if_kill_i = 1; if_req_i = 0;
        tick();
        if_kill_i = 0;
        chk("k_busy_hold", mem_req_o, 1);
        mem_ack_i = 1; mem_rdata_i = 32'h1234;
        tick();
        mem_ack_i = 0;
        chk("k_resp_novalid", if_valid_o, 0);
        chk("k_resp_req", mem_req_o, 0);
        tick();
        chk("k_idle_novalid", if_valid_o, 0);
        if_req_i = 1; if_addr_i = 32'h60;
        tick();
        chk("k_next_addr", mem_addr_o, 32'h60);
        mem_ack_i = 1; mem_rdata_i = 32'h6060;
        tick();
        mem_ack_i = 0;
        chk("k_next_valid", if_valid_o, 1);
        chk("k_next_rdata", if_rdata_o, 32'h6060);
        if_req_i = 0;
        tick();

        // store with one wait cycle before ack
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h80; dm_wdata_i = 32'h55;
        tick();
        chk("w_we", mem_we_o, 1);
        chk("w_wdata", mem_wdata_o, 32'h55);
        chk("w_addr", mem_addr_o, 32'h80);
        tick();
        chk("w_wait_req", mem_req_o, 1);
        chk("w_wait_novalid", dm_valid_o, 0);
        mem_ack_i = 1; mem_rdata_i = 32'hFFFF;
        tick();
        mem_ack_i = 0;
        chk("w_valid", dm_valid_o, 1);
        chk("w_req_low", mem_req_o, 0);
        dm_req_i = 0; dm_we_i = 0;
        tick();
        chk("w_valid_pulse", dm_valid_o, 0);

        // reset during BUSY_D, late ack ignored
        dm_req_i = 1; dm_addr_i = 32'h90; dm_wdata_i = 32'h77;
        tick();
        chk("r_busy_req", mem_req_o, 1);
        #2 reset = 1'b0;
        #1;
        chk("r_mem_req", mem_req_o, 0);
        chk("r_mem_addr", mem_addr_o, 0);
        chk("r_mem_wdata", mem_wdata_o, 0);
        chk("r_dm_rdata", dm_rdata_o, 0);
        chk("r_if_rdata", if_rdata_o, 0);
        dm_req_i = 0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        mem_ack_i = 1; mem_rdata_i = 32'hBAD0;
        tick();
        mem_ack_i = 0;
        chk("r_late_dvalid", dm_valid_o, 0);
        chk("r_late_ivalid", if_valid_o, 0);
        chk("r_late_rdata", dm_rdata_o, 0);
        tick();
        chk("r_late_dvalid2", dm_valid_o, 0);
        chk("r_late_req", mem_req_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
